vedic_mult_seq: RTL and testbench
=================================

// Module: vedic_mult_seq
// PURPOSE
//  Parametrised, multi-cycle Urdhva-Tiryagbhyam (vertical-crosswise) unsigned multiplier.
//  Successor to the fixed 3-bit combinational Vedic multiplier.
//  - Resolves one crosswise column per clock with a running carry, keeping area small at large WIDTH.
//  - valid/ready handshakes on both the operand side and the product side.
//  - Sits between operand producers (datapath, ALU issue) and a consumer that may apply backpressure.
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range 2..32; product width is 2*WIDTH
// PORTS
//  clk        in   1        single clock; all state updates on rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        operands a, b valid this cycle
//  in_ready   out  1        block can accept operands (high only in IDLE)
//  a          in   WIDTH    multiplicand, unsigned
//  b          in   WIDTH    multiplier, unsigned
//  out_valid  out  1        mul holds a finished product
//  out_ready  in   1        consumer takes the product this cycle
//  mul        out  2*WIDTH  product a*b, unsigned
//  busy       out  1        high in CALC
// BEHAVIOUR
//  Reset (rst=1 at clk edge, any state, including mid-CALC):
//    state=IDLE; mul=0; out_valid=0; busy=0; col=0; carry=0; operand regs=0.
//    An in-flight operation is discarded with no output.
//  in_ready = (state==IDLE) & ~rst. It is combinational from state only, never from in_valid.
//  FSM IDLE:
//    If in_valid, latch a->ra and b->rb; col=0; carry=0; mul=0. Go to CALC.
//  FSM CALC (busy=1), one column per cycle, col = 0..2*WIDTH-2:
//    s = carry + sum over i of (ra[i] & rb[col-i]), for i in max(0,col-WIDTH+1)..min(col,WIDTH-1).
//    mul[col] <= s[0]; carry <= s >> 1; col <= col+1.
//  Widths:
//    s and carry are CW = $clog2(WIDTH)+2 bits, which is sufficient with no overflow.
//    After the last column, the carry is <=1.
//    On the col==2*WIDTH-2 cycle, also write mul[2*WIDTH-1] <= s[1]. Go to DONE.
//  FSM DONE:
//    out_valid=1; mul stable.
//    If out_ready, go to IDLE and drop out_valid on the next cycle; mul keeps its value until the next accept.
//    If ~out_ready, hold DONE indefinitely with mul unchanged.
//  Latency:
//    Operand accept at edge E. Columns computed in cycles E+1..E+2*WIDTH-1.
//    out_valid is high from cycle E+2*WIDTH-1+1 = E+2*WIDTH.
//  Throughput:
//    One product per 2*WIDTH+1 cycles with out_ready tied high.
//    The DONE->IDLE cycle is not overlapped with a new accept.
//  in_valid while not IDLE is ignored: no latch, no state change; the producer must hold until in_ready.
//  a and b are sampled only at accept. Later changes do not affect the product in progress.
//  Boundaries:
//    a=0 or b=0 gives mul=0 with the same latency.
//    All-ones operands yield (2^WIDTH-1)^2 with no carry loss.
//  out_valid and in_ready are never high in the same cycle.
// TESTING
//  WIDTH=3, a=3'b110, b=3'b111, out_ready=1 -> out_valid at accept+6 cycles, mul=6'b101010 (42), in_ready back after 1 cycle.
//  WIDTH=8, a=8'hFF, b=8'hFF -> mul=16'hFE01 at accept+16; a=8'h00, b=8'hA5 -> mul=16'h0000, same latency.
//  WIDTH=8, a=8'h0C, b=8'h0D, out_ready=0 for 10 cycles after out_valid -> mul=16'h009C held stable and out_valid=1 throughout; in_ready stays 0; 1 cycle after out_ready=1, out_valid=0 and in_ready=1.
//  WIDTH=8, in_valid pulsed with a=8'h11, b=8'h22 during CALC of 8'h03*8'h05 -> result 16'h000F only; second request ignored; busy continuous.
//  WIDTH=8, rst=1 at column 4 of 8'h7F*8'h81 -> next cycle state IDLE, mul=0, out_valid=0, busy=0, in_ready=1; then 8'h02*8'h03 -> 16'h0006.
//  Random: 10k random operand pairs at WIDTH=3,8,16,32 with random out_ready -> mul == a*b, latency exact, no dropped or duplicated products.

Source files
------------

// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam (vertical-crosswise) unsigned multiplier.
// Resolves one crosswise column per clock with a running carry; valid/ready on both sides.
module vedic_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] mul,
    output logic               busy
);

    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(WIDTH) + 2;
    localparam int COLW = $clog2(PW);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [WIDTH-1:0]          r_ra;
    logic [WIDTH-1:0]          r_rb;
    logic [COLW-1:0]           r_col;
    logic [CW-1:0]             r_carry;
    logic [PW-1:0]             r_mul;
    logic [CW-1:0]             w_sum;
    logic                      w_last;
    logic [WIDTH-1:0][PW-1:0]  w_pp;

    // Row i holds ra[i]*rb shifted to weight i, so bit col of row i is ra[i]&rb[col-i]
    // (zero outside the crosswise range).
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
        assign w_pp[gi] = r_ra[gi] ? ({{WIDTH{1'b0}}, r_rb} << gi) : '0;
    end

    always_comb begin
        w_sum = r_carry;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum = w_sum + CW'(w_pp[i][r_col]);
        end
    end

    assign w_last = (r_col == COLW'(PW - 2));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_CALC;
            S_CALC:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (r_state == S_IDLE) & ~rst;
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_CALC);
    end

    assign mul = r_mul;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_col   <= '0;
            r_carry <= '0;
            r_mul   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_ra    <= a;
                    r_rb    <= b;
                    r_col   <= '0;
                    r_carry <= '0;
                    r_mul   <= '0;
                end
                S_CALC: begin
                    r_mul[r_col] <= w_sum[0];
                    r_carry      <= w_sum >> 1;
                    r_col        <= r_col + COLW'(1);
                    // Final column: remaining carry is at most 1 and becomes the top bit.
                    if (w_last) r_mul[PW-1] <= w_sum[1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq at WIDTH=8 (main) and WIDTH=3 (small case).
module tb_vedic_mult_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] mul;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [2:0]  a3, b3;
    logic [5:0]  mul3;

    int n_chk  = 0;
    int n_fail = 0;

    vedic_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .mul(mul), .busy(busy)
    );

    vedic_mult_seq #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3),
        .mul(mul3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for in_ready, presents operands for one edge, then scrambles them.
    task automatic start8(input logic [7:0] xa, input logic [7:0] xb, output bit ok);
        int t;
        t  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'(1));
            ok = 1'b0;
            return;
        end
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    // Counts edges from the accept edge (counted as 1) until out_valid is seen.
    task automatic wait_done8(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] xa, input logic [7:0] xb, input int stall);
        int          lat;
        bit          ok;
        logic [15:0] exp;
        exp = 16'(xa) * 16'(xb);
        out_ready = (stall == 0);
        start8(xa, xb, ok);
        if (!ok) return;
        wait_done8(lat);
        check({tag, "_lat"}, 64'(lat), 64'(16));
        check({tag, "_mul"}, 64'(mul), 64'(exp));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, 64'(out_valid), 64'(1));
            check({tag, "_hold_mul"}, 64'(mul), 64'(exp));
            check({tag, "_hold_rdy"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drop_vld"}, 64'(out_valid), 64'(0));
        check({tag, "_back_rdy"}, 64'(in_ready), 64'(1));
        check({tag, "_keep_mul"}, 64'(mul), 64'(exp));
    endtask

    initial begin
        int gaps;
        int lat;
        bit ok;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = '0; b3 = '0;

        repeat (2) @(negedge clk);
        check("rst_mul",  64'(mul), 64'(0));
        check("rst_vld",  64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rdy",  64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("idle_rdy", 64'(in_ready), 64'(1));

        // WIDTH=3: 6*7 = 42
        @(negedge clk);
        in_valid3 = 1'b1; a3 = 3'b110; b3 = 3'b111;
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0; a3 = 3'b001; b3 = 3'b001;
        lat = 1;
        while (!out_valid3 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("w3_lat", 64'(lat), 64'(6));
        check("w3_mul", 64'(mul3), 64'(42));
        check("w3_rdy_excl", 64'(in_ready3), 64'(0));
        @(negedge clk);
        check("w3_drop_vld", 64'(out_valid3), 64'(0));
        check("w3_back_rdy", 64'(in_ready3), 64'(1));

        // WIDTH=8 directed vectors
        run8("ff_ff", 8'hFF, 8'hFF, 0);
        run8("zero_a", 8'h00, 8'hA5, 0);
        run8("zero_b", 8'hA5, 8'h00, 0);
        run8("stall", 8'h0C, 8'h0D, 10);
        run8("h80_h80", 8'h80, 8'h80, 0);
        run8("h01_hff", 8'h01, 8'hFF, 2);
        run8("hb7_h5e", 8'hB7, 8'h5E, 1);

        // Request pulsed mid-calculation must be ignored.
        out_ready = 1'b1;
        gaps = 0;
        start8(8'h03, 8'h05, ok);
        for (int k = 0; k < 15; k++) begin
            if (!busy) gaps++;
            if (k == 2) begin in_valid = 1'b1; a = 8'h11; b = 8'h22; end
            if (k == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        check("ign_busy_gaps", 64'(gaps), 64'(0));
        check("ign_vld", 64'(out_valid), 64'(1));
        check("ign_mul", 64'(mul), 64'(16'h000F));
        gaps = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || out_valid) gaps++;
        end
        check("ign_no_dup", 64'(gaps), 64'(0));

        // Synchronous reset while column 4 is being resolved.
        start8(8'h7F, 8'h81, ok);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_mul",  64'(mul), 64'(0));
        check("mid_rst_vld",  64'(out_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_rdy",  64'(in_ready), 64'(1));
        run8("post_rst", 8'h02, 8'h03, 0);

        // Random operand pairs with random backpressure.
        for (int k = 0; k < 60; k++) begin
            run8("rnd", 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
